// File: rtl/vfd_pkg.sv
// Shared constants for the VFD operator frequency controller: FSM state codes,
// key indices and frequency width.
package vfd_pkg;

  localparam int unsigned FW = 10;

  localparam int K_UP  = 0;
  localparam int K_DN  = 1;
  localparam int K_RUN = 2;

  typedef enum logic [2:0] {
    ST_STOP     = 3'd0,
    ST_ACCEL    = 3'd1,
    ST_RUN      = 3'd2,
    ST_DECEL    = 3'd3,
    ST_STOPPING = 3'd4
  } vfd_state_e;

  function automatic logic is_ramp(input vfd_state_e s);
    return s inside {ST_ACCEL, ST_DECEL, ST_STOPPING};
  endfunction

  function automatic logic is_on(input vfd_state_e s);
    return s inside {ST_ACCEL, ST_RUN, ST_DECEL};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronise and debounce one raw active-low panel key; emit a one-cycle press pulse.
// VFD_KEY_REPEAT_EN adds auto-repeat while the key is held (per-instance REPEAT enable).
module key_debounce #(
  parameter logic [19:0] DB_CNT = 20'd1000000
`ifdef VFD_KEY_REPEAT_EN
  , parameter bit REPEAT = 1'b1
`endif
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic key_in,
  output logic key_lvl,
  output logic key_press
);

  logic [1:0]  sync_q;
  logic [19:0] cnt_q;
  logic        lvl_q;
  logic        edge_q;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      lvl_q  <= 1'b1;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], key_in};
      edge_q <= 1'b0;
      if (sync_q[1] != lvl_q) begin
        if (cnt_q == DB_CNT - 20'd1) begin
          lvl_q  <= sync_q[1];
          cnt_q  <= '0;
          edge_q <= ~sync_q[1];
        end else begin
          cnt_q <= cnt_q + 20'd1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign key_lvl = lvl_q;

`ifdef VFD_KEY_REPEAT_EN
  localparam logic [25:0] REP_FIRST_M1 = 26'(32 * DB_CNT - 1);
  localparam logic [25:0] REP_NEXT_M1  = 26'(8 * DB_CNT - 1);

  logic [25:0] rep_cnt_q;
  logic        rep_armed_q;
  logic        rep_q;

  // Hold time is counted from the debounced fall; first repeat waits longer than the rest.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
      rep_q       <= 1'b0;
    end else begin
      rep_q <= 1'b0;
      if (!REPEAT || lvl_q) begin
        rep_cnt_q   <= '0;
        rep_armed_q <= 1'b0;
      end else if (rep_cnt_q == (rep_armed_q ? REP_NEXT_M1 : REP_FIRST_M1)) begin
        rep_q       <= 1'b1;
        rep_cnt_q   <= '0;
        rep_armed_q <= 1'b1;
      end else begin
        rep_cnt_q <= rep_cnt_q + 26'd1;
      end
    end
  end

  assign key_press = edge_q | rep_q;
`else
  assign key_press = edge_q;
`endif

endmodule

// File: rtl/vfd_freq_ctrl.sv
// Operator frequency controller: keys -> setpoint, run/stop FSM and fixed-rate ramp.
// Optional key auto-repeat is enabled by defining VFD_KEY_REPEAT_EN.
module vfd_freq_ctrl
  import vfd_pkg::*;
#(
  parameter logic [19:0] DB_CNT   = 20'd1000000,
  parameter logic [23:0] RAMP_DIV = 24'd5000000,
  parameter logic [9:0]  F_MIN    = 10'd5,
  parameter logic [9:0]  F_MAX    = 10'd500,
  parameter logic [9:0]  F_DEF    = 10'd50,
  parameter logic [9:0]  STEP     = 10'd1
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic [2:0]    key,
  output logic [FW-1:0] freq,
  output logic [FW-1:0] freq_set,
  output logic          run,
  output logic          busy,
  output logic [2:0]    state
);

  logic [2:0] key_press;

  for (genvar i = 0; i < 3; i++) begin : g_key
    key_debounce #(
      .DB_CNT(DB_CNT)
`ifdef VFD_KEY_REPEAT_EN
      , .REPEAT(i != K_RUN)
`endif
    ) u_db (
      .clk_sys  (clk_sys),
      .rst_n    (rst_n),
      .key_in   (key[i]),
      .key_lvl  (),
      .key_press(key_press[i])
    );
  end

  logic up_p, dn_p, run_p;
  assign up_p  = key_press[K_UP] & ~key_press[K_DN];
  assign dn_p  = key_press[K_DN] & ~key_press[K_UP];
  assign run_p = key_press[K_RUN];

  logic [FW:0]   sp_inc, sp_floor;
  logic [FW-1:0] sp_d;

  always_comb begin
    sp_inc   = {1'b0, freq_set} + {1'b0, STEP};
    sp_floor = {1'b0, F_MIN} + {1'b0, STEP};
    sp_d     = freq_set;
    if (up_p)
      sp_d = (sp_inc > {1'b0, F_MAX}) ? F_MAX : sp_inc[FW-1:0];
    else if (dn_p)
      sp_d = ({1'b0, freq_set} < sp_floor) ? F_MIN : freq_set - STEP;
  end

  vfd_state_e    state_q, state_d;
  logic [FW-1:0] freq_q, freq_d;
  logic [23:0]   ramp_cnt_q;
  logic          tick;

  assign tick = busy && (ramp_cnt_q == RAMP_DIV - 24'd1);

  always_comb begin
    state_d = state_q;
    freq_d  = freq_q;
    case (state_q)
      ST_STOP: begin
        freq_d = '0;
        if (run_p) state_d = ST_ACCEL;
      end
      ST_ACCEL: begin
        if (run_p)                   state_d = ST_STOPPING;
        else if (freq_q == freq_set) state_d = ST_RUN;
        else if (freq_set < freq_q)  state_d = ST_DECEL;
        else if (tick && freq_q < F_MAX) freq_d = freq_q + 1'b1;
      end
      ST_RUN: begin
        if (run_p)                  state_d = ST_STOPPING;
        else if (freq_set > freq_q) state_d = ST_ACCEL;
        else if (freq_set < freq_q) state_d = ST_DECEL;
      end
      ST_DECEL: begin
        if (run_p)                   state_d = ST_STOPPING;
        else if (freq_q == freq_set) state_d = ST_RUN;
        else if (freq_set > freq_q)  state_d = ST_ACCEL;
        else if (tick && freq_q != '0) freq_d = freq_q - 1'b1;
      end
      ST_STOPPING: begin
        if (run_p)             state_d = (freq_set < freq_q) ? ST_DECEL : ST_ACCEL;
        else if (freq_q == '0) state_d = ST_STOP;
        else if (tick)         freq_d = freq_q - 1'b1;
      end
      default: begin
        state_d = ST_STOP;
        freq_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_STOP;
      freq_q     <= '0;
      freq_set   <= F_DEF;
      run        <= 1'b0;
      busy       <= 1'b0;
      ramp_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      freq_q   <= freq_d;
      freq_set <= sp_d;
      run      <= is_on(state_d);
      busy     <= is_ramp(state_d);
      // busy mirrors state_q, so the counter restarts on every entry into a ramp state
      if (state_d != state_q || !busy || tick)
        ramp_cnt_q <= '0;
      else
        ramp_cnt_q <= ramp_cnt_q + 24'd1;
    end
  end

  assign freq  = freq_q;
  assign state = state_q;

endmodule

// File: tb/tb_vfd_freq_ctrl.sv
// Self-checking bench for vfd_freq_ctrl with DB_CNT=4, RAMP_DIV=8; setpoint changes go
// through a scoreboard queue, FSM/ramp corners are checked by hand-written sequences.
module tb_vfd_freq_ctrl;

  logic       clk_sys = 1'b0;
  logic       rst_n   = 1'b0;
  logic [2:0] key     = 3'b111;
  logic [9:0] freq, freq_set;
  logic       run, busy;
  logic [2:0] state;

  always #5 clk_sys = ~clk_sys;

  vfd_freq_ctrl #(
    .DB_CNT  (20'd4),
    .RAMP_DIV(24'd8),
    .F_MIN   (10'd5),
    .F_MAX   (10'd500),
    .F_DEF   (10'd50),
    .STEP    (10'd1)
  ) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .key     (key),
    .freq    (freq),
    .freq_set(freq_set),
    .run     (run),
    .busy    (busy),
    .state   (state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every observed setpoint change must match the next queued expectation.
  int         sp_q[$];
  logic       mon_en = 1'b0;
  logic [9:0] last_set = 10'd50;

  always @(negedge clk_sys) begin
    if (mon_en && freq_set != last_set) begin
      if (sp_q.size() == 0)
        chk("sp_unexpected_change", int'(freq_set), int'(last_set));
      else
        chk("sp_scoreboard", int'(freq_set), sp_q.pop_front());
      last_set = freq_set;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic press(input logic [2:0] mask);
    key = ~mask;
    cyc(8);
    key = 3'b111;
    cyc(10);
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int n = 0;
    while (int'(state) != s && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    chk(name, int'(state), s);
  endtask

  task automatic wait_fs(input int f, input int s, input int budget, input string name);
    int n = 0;
    while ((int'(freq) != f || int'(state) != s) && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    chk({name, "_freq"}, int'(freq), f);
    chk({name, "_state"}, int'(state), s);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    cyc(2);
    rst_n    = 1'b1;
    last_set = 10'd50;
    mon_en   = 1'b1;
  endtask

  typedef struct {
    string      name;
    logic [2:0] mask;   // pressed keys: [0] up, [1] down
    int         exp_set;
    bit         changes;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"tbl_up_52",   3'b001, 52, 1'b1};
    vecs[1] = '{"tbl_dn_51",   3'b010, 51, 1'b1};
    vecs[2] = '{"tbl_dn_50",   3'b010, 50, 1'b1};
    vecs[3] = '{"tbl_both_50", 3'b011, 50, 1'b0};
    vecs[4] = '{"tbl_up_51",   3'b001, 51, 1'b1};
    vecs[5] = '{"tbl_dn_50b",  3'b010, 50, 1'b1};

    cyc(3);
    chk("rst_freq", int'(freq), 0);
    chk("rst_set", int'(freq_set), 50);
    chk("rst_run", int'(run), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_state", int'(state), 0);
    rst_n = 1'b1;
    cyc(100);
    chk("idle_freq", int'(freq), 0);
    chk("idle_set", int'(freq_set), 50);
    chk("idle_run", int'(run), 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_state", int'(state), 0);
    last_set = 10'd50;
    mon_en   = 1'b1;

    key = 3'b110; cyc(2); key = 3'b111; cyc(20);
    chk("glitch_set", int'(freq_set), 50);

    sp_q.push_back(51);
    key = 3'b110;
    cyc(5);
    chk("up_latency_before", int'(freq_set), 50);
    cyc(2);
    chk("up_latency_after", int'(freq_set), 51);
    cyc(13);
    key = 3'b111;
    cyc(20);
    chk("up_once", int'(freq_set), 51);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].changes) sp_q.push_back(vecs[i].exp_set);
      press(vecs[i].mask);
      chk(vecs[i].name, int'(freq_set), vecs[i].exp_set);
      chk({vecs[i].name, "_state"}, int'(state), 0);
    end

    key = 3'b011;
    wait_state(1, 20, "run_to_accel");
    key = 3'b111;
    chk("accel_run", int'(run), 1);
    chk("accel_busy", int'(busy), 1);
    cyc(7);
    chk("ramp_first_pre", int'(freq), 0);
    cyc(1);
    chk("ramp_first_step", int'(freq), 1);
    cyc(8);
    chk("ramp_second_step", int'(freq), 2);
    wait_fs(50, 2, 600, "accel_reach");
    chk("run_busy", int'(busy), 0);
    chk("run_run", int'(run), 1);

    sp_q.push_back(49);
    key = 3'b101;
    cyc(10);
    chk("decel_entry", int'(state), 3);
    key = 3'b111;
    cyc(10);
    sp_q.push_back(48); press(3'b010);
    sp_q.push_back(47); press(3'b010);
    wait_fs(47, 2, 300, "decel_reach");
    chk("decel_done_busy", int'(busy), 0);

    do_reset();
    key = 3'b011; wait_state(1, 20, "st1_accel"); key = 3'b111;
    wait_fs(20, 1, 300, "st1_at20");
    key = 3'b011; wait_state(4, 20, "st1_stopping"); key = 3'b111;
    chk("stopping_run", int'(run), 0);
    chk("stopping_busy", int'(busy), 1);
    wait_fs(0, 0, 400, "st1_stop");
    chk("stop_run", int'(run), 0);
    chk("stop_busy", int'(busy), 0);

    key = 3'b011; wait_state(1, 20, "st2_accel"); key = 3'b111;
    wait_fs(20, 1, 300, "st2_at20");
    key = 3'b011; wait_state(4, 20, "st2_stopping"); key = 3'b111;
    wait_fs(10, 4, 200, "st2_at10");
    key = 3'b011; wait_state(1, 20, "st2_restart_accel"); key = 3'b111;
    chk("restart_run", int'(run), 1);
    cyc(10);

    for (int v = 49; v >= 5; v--) begin
      sp_q.push_back(v);
      press(3'b010);
    end
    press(3'b010);
    chk("sat_min", int'(freq_set), 5);
    press(3'b011);
    chk("both_at_min", int'(freq_set), 5);
    for (int v = 6; v <= 500; v++) begin
      sp_q.push_back(v);
      press(3'b001);
    end
    press(3'b001);
    chk("sat_max", int'(freq_set), 500);
    press(3'b011);
    chk("both_at_max", int'(freq_set), 500);

    do_reset();
    key = 3'b011; wait_state(1, 20, "ar_accel"); key = 3'b111;
    wait_fs(30, 1, 400, "ar_at30");
    mon_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("async_freq", int'(freq), 0);
    chk("async_set", int'(freq_set), 50);
    chk("async_run", int'(run), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_state", int'(state), 0);
    cyc(2);
    rst_n    = 1'b1;
    last_set = 10'd50;
    mon_en   = 1'b1;

`ifdef VFD_KEY_REPEAT_EN
    cyc(5);
    for (int v = 51; v <= 57; v++) sp_q.push_back(v);
    key = 3'b110;
    cyc(300);
    key = 3'b111;
    cyc(30);
    chk("repeat_final_set", int'(freq_set), 57);
`endif

    cyc(5);
    chk("sp_queue_drained", sp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
